wb_stage: RTL and testbench

- Writeback stage of the in-order RV64 core. Sits between the memory stage and the register file, and drives the regfile write port (w_addr/w_data/w_ena).
- One registered pipeline slot with a valid/ready handshake upstream and a hold input for the commit/difftest side.
- Formats load data by funct3 and byte offset, exposes a forwarding bypass, and counts retired instructions.

---
 rtl/wb_stage.sv | 122 ++++++++++++
 tb/tb_wb_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage of the in-order RV64 core: one registered slot between the memory
// stage and the register file, with load formatting, a bypass port and a retire counter.
module wb_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic            wb_hold,
  output logic [4:0]      w_addr,
  output logic [XLEN-1:0] w_data,
  output logic            w_ena,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            load_fmt_err,
  output logic [63:0]     instret
);

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rd;
    logic            rd_wen;
    logic [XLEN-1:0] data;
    logic            fmt_err;
  } slot_t;

  logic            r_valid;
  slot_t           r_slot;
  logic [CW-1:0]   r_instret;

  logic            w_capture;
  logic            w_commit;
  logic            w_rd_live;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_word;
  logic [XLEN-1:0] w_load_data;
  logic            w_load_err;
  slot_t           w_next;

  // Slot accepts when empty or when its occupant retires this cycle.
  assign in_ready  = !r_valid || !wb_hold;
  assign w_capture = in_valid && in_ready;
  assign w_commit  = r_valid && !wb_hold;
  assign w_rd_live = r_slot.rd_wen && (r_slot.rd != '0);

  // Lane select ignores address bits below the access size.
  always_comb begin : load_fmt
    w_byte      = 8'(in_mem_rdata >> {in_addr_lo, 3'b000});
    w_half      = 16'(in_mem_rdata >> {in_addr_lo[2:1], 4'b0000});
    w_word      = 32'(in_mem_rdata >> {in_addr_lo[2], 5'b00000});
    w_load_data = '0;
    w_load_err  = 1'b0;
    case (in_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_load_data = {{(XLEN-32){w_word[31]}}, w_word};
      3'b110:  w_load_data = {{(XLEN-32){1'b0}}, w_word};
      3'b011:  w_load_data = in_mem_rdata;
      default: w_load_err  = 1'b1;
    endcase
  end

  always_comb begin : next_slot
    w_next         = '0;
    w_next.pc      = in_pc;
    w_next.rd      = in_rd;
    w_next.rd_wen  = in_rd_wen;
    w_next.data    = in_is_load ? w_load_data : in_result;
    w_next.fmt_err = in_is_load && w_load_err;
  end

  // Capture and commit in the same cycle replaces the occupant without a bubble.
  always_ff @(posedge clk or negedge rst) begin : slot_reg
    if (!rst) begin
      r_valid <= 1'b0;
      r_slot  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_slot  <= w_next;
    end else if (w_commit) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : instret_reg
    if (!rst) begin
      r_instret <= '0;
    end else if (w_commit) begin
      r_instret <= r_instret + CW'(1);
    end
  end

  assign w_addr       = r_slot.rd;
  assign w_data       = r_slot.data;
  assign w_ena        = w_commit && w_rd_live;
  assign fwd_valid    = r_valid && w_rd_live;
  assign fwd_rd       = r_slot.rd;
  assign fwd_data     = r_slot.data;
  assign commit_valid = w_commit;
  assign commit_pc    = r_slot.pc;
  assign load_fmt_err = w_commit && r_slot.fmt_err;
  assign instret      = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes expected retirements, a negedge monitor
// pops and compares them against the regfile, bypass and commit ports.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_result;
  logic [63:0] in_mem_rdata;
  logic        wb_hold;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        w_ena;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        load_fmt_err;
  logic [63:0] instret;

  wb_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_result(in_result), .in_mem_rdata(in_mem_rdata),
    .wb_hold(wb_hold), .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .load_fmt_err(load_fmt_err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_cnt = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Reference load result from the access size and signedness.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] a,
                                           input logic [63:0] d, output logic err);
    int unsigned nb;
    int unsigned base;
    logic [63:0] v;
    logic [63:0] mask;
    err = 1'b0;
    if (f3 == 3'b111) begin
      err = 1'b1;
      return 64'd0;
    end
    nb   = 1 << f3[1:0];
    base = (int'(a) / nb) * nb;
    v    = d >> (8 * base);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One cycle of stimulus; called just after a rising edge.
  task automatic cycle(input bit v, input bit hold, input logic [63:0] pc, input logic [4:0] rd,
                       input bit wen, input bit ld, input logic [2:0] f3, input logic [2:0] alo,
                       input logic [63:0] res, input logic [63:0] rdata,
                       input bit use_exp, input logic [63:0] exp_d);
    bit   cap;
    exp_t e;
    logic err;
    in_valid = v; wb_hold = hold; in_pc = pc; in_rd = rd; in_rd_wen = wen;
    in_is_load = ld; in_funct3 = f3; in_addr_lo = alo; in_result = res; in_mem_rdata = rdata;
    cap   = v && (q.size() == 0 || !hold);
    e.pc  = pc; e.rd = rd; e.wen = wen;
    if (ld) begin
      e.data = ref_load(f3, alo, rdata, err);
      e.err  = err;
    end else begin
      e.data = res;
      e.err  = 1'b0;
    end
    if (use_exp) e.data = exp_d;
    @(posedge clk);
    if (cap) q.push_back(e);
    #1;
  endtask

  task automatic alu(input logic [63:0] pc, input logic [4:0] rd, input bit wen,
                     input logic [63:0] res, input bit hold);
    cycle(1'b1, hold, pc, rd, wen, 1'b0, 3'($urandom), 3'($urandom), res,
          {$urandom, $urandom}, 1'b0, 64'd0);
  endtask

  task automatic load(input logic [63:0] pc, input logic [2:0] f3, input logic [2:0] alo,
                      input logic [63:0] rdata, input logic [63:0] exp_d);
    cycle(1'b1, 1'b0, pc, 5'd7, 1'b1, 1'b1, f3, alo, {$urandom, $urandom}, rdata, 1'b1, exp_d);
  endtask

  task automatic idle(input bit hold);
    cycle(1'b0, hold, 64'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0, 1'b0, 64'd0);
  endtask

  // Monitor: slot occupancy is the queue depth at mid-cycle.
  always @(negedge clk) begin : monitor
    bit   slot;
    bit   exp_c;
    exp_t h;
    if (mon_en) begin
      slot  = (q.size() != 0);
      exp_c = slot && !wb_hold;
      chk1("in_ready", in_ready, !slot || !wb_hold);
      chk1("commit_valid", commit_valid, exp_c);
      chk("instret", instret, model_cnt);
      if (slot) begin
        h = q[0];
        chk1("fwd_valid", fwd_valid, h.wen && h.rd != 5'd0);
        chk1("w_ena", w_ena, exp_c && h.wen && h.rd != 5'd0);
        chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
        chk("fwd_data", fwd_data, h.data);
        chk("w_addr", 64'(w_addr), 64'(h.rd));
        chk("w_data", w_data, h.data);
        if (exp_c) begin
          chk("commit_pc", commit_pc, h.pc);
          chk1("load_fmt_err", load_fmt_err, h.err);
          void'(q.pop_front());
          model_cnt = model_cnt + 64'd1;
        end else begin
          chk1("load_fmt_err_idle", load_fmt_err, 1'b0);
        end
      end else begin
        chk1("fwd_valid_empty", fwd_valid, 1'b0);
        chk1("w_ena_empty", w_ena, 1'b0);
        chk1("load_fmt_err_empty", load_fmt_err, 1'b0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_w_ena"}, w_ena, 1'b0);
    chk1({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    chk1({tag, "_commit_valid"}, commit_valid, 1'b0);
    chk1({tag, "_load_fmt_err"}, load_fmt_err, 1'b0);
    chk({tag, "_w_addr"}, 64'(w_addr), 64'd0);
    chk({tag, "_w_data"}, w_data, 64'd0);
    chk({tag, "_fwd_data"}, fwd_data, 64'd0);
    chk({tag, "_commit_pc"}, commit_pc, 64'd0);
    chk({tag, "_instret"}, instret, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; wb_hold = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
    in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0; in_result = '0; in_mem_rdata = '0;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    // Basic ALU writeback then an idle cycle.
    alu(64'h1000, 5'd5, 1'b1, 64'h1234, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("instret_after_first", instret, 64'd1);

    // Load formatting.
    load(64'h1004, 3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load(64'h1008, 3'b100, 3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    load(64'h100C, 3'b010, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    load(64'h1010, 3'b110, 3'd5, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    load(64'h1014, 3'b101, 3'd6, 64'h8765_4321_0000_0000, 64'h0000_0000_0000_8765);
    load(64'h1018, 3'b001, 3'd7, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_8765);
    load(64'h101C, 3'b011, 3'd5, 64'h8765_4321_0BAD_F00D, 64'h8765_4321_0BAD_F00D);
    load(64'h1020, 3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    idle(1'b0);

    // Hold with a valid slot and upstream pressure, then back-to-back release.
    alu(64'h2000, 5'd10, 1'b1, 64'hAAAA, 1'b0);
    for (int i = 0; i < 3; i++) alu(64'h2004, 5'd11, 1'b1, 64'hBBBB, 1'b1);
    chk("instret_frozen", instret, model_cnt);
    alu(64'h2004, 5'd11, 1'b1, 64'hBBBB, 1'b0);
    alu(64'h2008, 5'd12, 1'b1, 64'hCCCC, 1'b0);
    idle(1'b0);

    // Write to x0 and a non-writing instruction still retire.
    alu(64'h3000, 5'd0, 1'b1, 64'hDEAD, 1'b0);
    alu(64'h3004, 5'd9, 1'b0, 64'hBEEF, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, {$urandom, $urandom},
            5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0);
    end
    idle(1'b0);
    idle(1'b0);

    // Counter wrap from all-ones.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    model_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.r_instret;
    idle(1'b0);
    alu(64'h4000, 5'd3, 1'b1, 64'h55, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("instret_wrap", instret, 64'd0);

    // Asynchronous reset while a held instruction occupies the slot.
    alu(64'h5000, 5'd4, 1'b1, 64'h77, 1'b0);
    idle(1'b1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midreset");
    q.delete();
    model_cnt = '0;
    wb_hold = 1'b0;
    @(posedge clk);
    #1 chk1("midreset_no_commit", commit_valid, 1'b0);
    chk("midreset_instret", instret, 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    alu(64'h6000, 5'd8, 1'b1, 64'h99, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("final_instret", instret, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
